// File: rtl/mat_mul_pkg.sv
// Shared definitions for the matrix-multiply datapath and its result drain.
package mat_mul_pkg;

  localparam int N_DEF     = 8;
  localparam int W_IN_DEF  = 8;
  localparam int W_OUT_DEF = 32;
  localparam int W_RES_DEF = 16;

  // One input operand element as consumed by mat_mul_wrapper.
  typedef logic signed [W_IN_DEF-1:0] mm_operand_t;

  // Full accumulated result matrix, element [i][j] at bits (i*N+j)*W_OUT.
  typedef logic signed [N_DEF-1:0][N_DEF-1:0][W_OUT_DEF-1:0] mm_result_t;

endpackage

// File: rtl/sat_shift_narrow.sv
// Narrows one signed accumulator element: arithmetic right shift, then saturate.
module sat_shift_narrow #(
  parameter int W_OUT = 32,
  parameter int W_RES = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [W_OUT-1:0] i_elem,
  output logic signed [W_RES-1:0] o_res
);

  // A value fits in W_RES bits when every bit from W_RES-1 upward equals the sign.
  function automatic logic signed [W_RES-1:0] sat_narrow(input logic signed [W_OUT-1:0] v);
    logic signed [W_OUT-1:0] s;
    logic [W_OUT-W_RES:0]    hi;
    s  = v >>> SHIFT;
    hi = s[W_OUT-1:W_RES-1];
    if ((&hi) || !(|hi)) begin
      return $signed(s[W_RES-1:0]);
    end else if (s[W_OUT-1]) begin
      return $signed({1'b1, {(W_RES-1){1'b0}}});
    end else begin
      return $signed({1'b0, {(W_RES-1){1'b1}}});
    end
  endfunction

  // Pure combinational lane.
  always_comb begin
    o_res = sat_narrow(i_elem);
  end

endmodule

// File: rtl/mat_mul_result_drain.sv
// Captures full result matrices into a 2-deep buffer and streams them one
// narrowed row per valid/ready beat; flags results lost to a full buffer.
module mat_mul_result_drain
  import mat_mul_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int W_RES = W_RES_DEF,
  parameter int SHIFT = 0,
  localparam int RW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   valid_in,
  input  logic [N*N*W_OUT-1:0]   result_in,
  input  logic                   clear_ovf,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [N*W_RES-1:0]     out_tdata,
  output logic                   out_tlast,
  output logic [RW-1:0]          out_row,
  output logic                   busy,
  output logic                   overflow
);

  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [1:0]           r_count;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [RW-1:0]        r_row;
  logic                 r_ovf;
  logic [N*N*W_OUT-1:0] r_mem [2];

  logic                 w_valid;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_pop;
  logic                 w_cap;
  logic                 w_drop;
  logic [N*W_OUT-1:0]   w_row_raw;
  logic [N*W_RES-1:0]   w_lanes;

  // Handshake and buffer-occupancy decisions; a pop frees a slot in the same edge.
  always_comb begin
    w_valid   = (r_count != 2'd0);
    w_last    = w_valid && (r_row == LAST_ROW);
    w_xfer    = w_valid && out_tready;
    w_pop     = w_xfer && w_last;
    w_cap     = valid_in && ((r_count != 2'd2) || w_pop);
    w_drop    = valid_in && (r_count == 2'd2) && !w_pop;
    w_row_raw = r_mem[r_rd_ptr][r_row*N*W_OUT +: N*W_OUT];
  end

  // Narrowing is done on the read side, one lane per column.
  for (genvar j = 0; j < N; j++) begin : g_lane
    sat_shift_narrow #(
      .W_OUT (W_OUT),
      .W_RES (W_RES),
      .SHIFT (SHIFT)
    ) u_lane (
      .i_elem (w_row_raw[j*W_OUT +: W_OUT]),
      .o_res  (w_lanes[j*W_RES +: W_RES])
    );
  end

  // Buffer control: pointers, occupancy, row counter and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_row    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_cap) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        if (w_last) begin
          r_row    <= '0;
          r_rd_ptr <= ~r_rd_ptr;
        end else begin
          r_row    <= r_row + 1'b1;
        end
      end
      r_count <= r_count + {1'b0, w_cap} - {1'b0, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Matrix storage holds data only; stale contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_mem[r_wr_ptr] <= result_in;
    end
  end

  // Outputs derive from registered state only.
  always_comb begin
    out_tvalid = w_valid;
    out_tdata  = w_valid ? w_lanes : '0;
    out_tlast  = w_last;
    out_row    = r_row;
    busy       = w_valid;
    overflow   = r_ovf;
  end

endmodule

// File: tb/tb_mat_mul_result_drain.sv
// Randomized and directed bench for mat_mul_result_drain against a queue-based model.
module tb_mat_mul_result_drain;

  localparam int NN = 8;
  localparam int WO = 32;
  localparam int WR = 16;
  localparam int MW = NN * NN * WO;
  localparam int DW = NN * WR;

  typedef logic [MW-1:0] mat_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          valid_in = 1'b0;
  logic [MW-1:0] result_in = '0;
  logic          clear_ovf = 1'b0;
  logic          out_tready = 1'b0;

  logic          tv0, tl0, busy0, ovf0;
  logic [DW-1:0] td0;
  logic [2:0]    row0;
  logic          tv4, tl4, busy4, ovf4;
  logic [DW-1:0] td4;
  logic [2:0]    row4;

  mat_mul_result_drain #(.N(NN), .W_OUT(WO), .W_RES(WR), .SHIFT(0)) u_dut (
    .clk (clk), .resetn (resetn), .valid_in (valid_in), .result_in (result_in),
    .clear_ovf (clear_ovf), .out_tvalid (tv0), .out_tready (out_tready),
    .out_tdata (td0), .out_tlast (tl0), .out_row (row0), .busy (busy0), .overflow (ovf0)
  );

  mat_mul_result_drain #(.N(NN), .W_OUT(WO), .W_RES(WR), .SHIFT(4)) u_dut_sh4 (
    .clk (clk), .resetn (resetn), .valid_in (valid_in), .result_in (result_in),
    .clear_ovf (clear_ovf), .out_tvalid (tv4), .out_tready (out_tready),
    .out_tdata (td4), .out_tlast (tl4), .out_row (row4), .busy (busy4), .overflow (ovf4)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  mat_t q[$];
  int   mrow = 0;
  bit   movf = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sat_ref(input longint v, input int sh);
    longint s;
    s = v >>> sh;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int sh);
    logic [DW-1:0]    r;
    logic signed [WO-1:0] e32;
    longint           e;
    longint           s;
    r = '0;
    if (q.size() != 0) begin
      for (int j = 0; j < NN; j++) begin
        e32 = q[0][(mrow*NN + j)*WO +: WO];
        e   = e32;
        s   = sat_ref(e, sh);
        r[j*WR +: WR] = s[WR-1:0];
      end
    end
    return r;
  endfunction

  // Model advance for one rising edge, using the inputs that are stable across it.
  task automatic model_update();
    bit nonempty, pop;
    int sz;
    if (!resetn) begin
      q.delete();
      mrow = 0;
      movf = 1'b0;
      return;
    end
    sz       = q.size();
    nonempty = (sz != 0);
    pop      = nonempty && out_tready && (mrow == NN-1);
    if (nonempty && out_tready) begin
      if (mrow == NN-1) begin
        void'(q.pop_front());
        mrow = 0;
      end else begin
        mrow++;
      end
    end
    if (valid_in && (sz < 2 || pop)) q.push_back(result_in);
    if (valid_in && sz == 2 && !pop) movf = 1'b1;
    else if (clear_ovf)               movf = 1'b0;
  endtask

  task automatic check_outputs();
    bit ne;
    ne = (q.size() != 0);
    check("tvalid",  256'(tv0),   256'(ne));
    check("tlast",   256'(tl0),   256'(ne && mrow == NN-1));
    check("row",     256'(row0),  256'(mrow));
    check("busy",    256'(busy0), 256'(ne));
    check("ovf",     256'(ovf0),  256'(movf));
    check("tdata",   256'(td0),   256'(exp_row(0)));
    check("tvalid4", 256'(tv4),   256'(ne));
    check("row4",    256'(row4),  256'(mrow));
    check("tlast4",  256'(tl4),   256'(ne && mrow == NN-1));
    check("busy4",   256'(busy4), 256'(ne));
    check("ovf4",    256'(ovf4),  256'(movf));
    check("tdata4",  256'(td4),   256'(exp_row(4)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic mat_t mat_seq();
    mat_t m;
    for (int i = 0; i < NN*NN; i++) m[i*WO +: WO] = WO'(i);
    return m;
  endfunction

  function automatic mat_t mat_sat();
    mat_t m;
    int   v [9];
    v = '{40000, -40000, 32767, -32768, -1, 'h123, -33, 32'sh7fffffff, 32'sh80000000};
    for (int i = 0; i < NN*NN; i++) m[i*WO +: WO] = WO'(v[i % 9]);
    return m;
  endfunction

  function automatic mat_t mat_rand();
    mat_t m;
    int   mode;
    for (int i = 0; i < NN*NN; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      m[i*WO +: WO] = $urandom;
      else if (mode == 1) m[i*WO +: WO] = WO'(int'($urandom_range(0, 80000)) - 40000);
      else                m[i*WO +: WO] = WO'(int'($urandom_range(0, 1200000)) - 600000);
    end
    return m;
  endfunction

  task automatic send(input mat_t m);
    valid_in  = 1'b1;
    result_in = m;
    cycle();
    valid_in  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) cycle();
    resetn = 1'b1;
    cycle();

    // Single sequential matrix, full-rate drain
    out_tready = 1'b1;
    send(mat_seq());
    repeat (10) cycle();

    // Saturation patterns on both shift settings
    send(mat_sat());
    repeat (10) cycle();

    // Backpressure from row 2 onward
    send(mat_seq());
    repeat (2) cycle();
    for (int k = 0; k < 24; k++) begin
      out_tready = (k % 4 == 0) || (k % 4 == 3);
      cycle();
    end
    out_tready = 1'b1;
    repeat (4) cycle();

    // Burst of three with the output stalled: third is dropped
    out_tready = 1'b0;
    send(mat_rand());
    cycle();
    send(mat_rand());
    cycle();
    send(mat_rand());
    repeat (2) cycle();
    out_tready = 1'b1;
    repeat (18) cycle();
    clear_ovf = 1'b1;
    cycle();
    clear_ovf = 1'b0;
    cycle();

    // Full buffer with capture coincident with the tlast transfer
    out_tready = 1'b0;
    send(mat_rand());
    send(mat_rand());
    out_tready = 1'b1;
    repeat (7) cycle();
    send(mat_rand());
    repeat (26) cycle();

    // Reset while draining row 3
    send(mat_rand());
    repeat (3) cycle();
    resetn = 1'b0;
    #1;
    check("rst_tvalid", 256'(tv0),   256'(0));
    check("rst_tdata",  256'(td0),   256'(0));
    check("rst_row",    256'(row0),  256'(0));
    check("rst_busy",   256'(busy0), 256'(0));
    check("rst_tlast",  256'(tl0),   256'(0));
    q.delete();
    mrow = 0;
    movf = 1'b0;
    @(negedge clk);
    cycle();
    resetn = 1'b1;
    send(mat_seq());
    repeat (10) cycle();

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      valid_in   = ($urandom_range(0, 3) == 0);
      result_in  = mat_rand();
      out_tready = ($urandom_range(0, 2) != 0);
      clear_ovf  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    valid_in   = 1'b0;
    clear_ovf  = 1'b0;
    out_tready = 1'b1;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_mul_result_drain.md
Name: mat_mul_result_drain

Overview:
- Downstream stage of mat_mul_wrapper. Captures each N x N accumulated result matrix when valid_out pulses.
- Buffers up to two results and narrows every W_OUT element to W_RES (arithmetic shift, then saturate).
- Streams the matrix one row per beat over a valid/ready interface with row-last marking.
- mat_mul_wrapper has no backpressure, so this block absorbs bursts and flags loss.

Parameters:
- N, 8, matrix dimension (rows/cols)
- W_OUT, 32, signed width of each incoming result element
- W_RES, 16, signed width of each output element (W_RES <= W_OUT)
- SHIFT, 0, arithmetic right shift applied before saturation (0 <= SHIFT < W_OUT)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- valid_in  in  1  one-cycle strobe from mat_mul_wrapper valid_out
- result_in  in  N*N*W_OUT  packed result; element [i][j] at bits (i*N+j)*W_OUT +: W_OUT, signed
- clear_ovf  in  1  synchronous clear of overflow
- out_tvalid  out  1  output beat valid
- out_tready  in  1  downstream ready
- out_tdata  out  N*W_RES  row beat; element j at j*W_RES +: W_RES
- out_tlast  out  1  high on beat of row N-1
- out_row  out  $clog2(N)  index of current row
- busy  out  1  buffer count != 0
- overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async assert, sync release): buffer count 0, wr/rd pointers 0, row counter 0, overflow 0. All outputs 0. Reset mid-stream discards all buffered data; no partial beat resumes.
- Storage: 2-entry FIFO of full matrices (raw W_OUT values). Narrowing is applied on the read side.
- Capture: on a clk edge with valid_in=1 and count<2, write result_in to slot wr_ptr, toggle wr_ptr, count+1.
- Drop: valid_in=1 with count==2 and no pop in the same cycle -> result discarded, overflow<=1. Buffer contents are untouched.
- Simultaneous pop and capture with count==2: the pop frees the slot in the same edge, so the capture is accepted, count stays 2, overflow unchanged.
- clear_ovf=1 clears overflow unless a drop occurs in the same cycle; a drop wins.
- Output beat:
  - out_tvalid = (count != 0).
  - out_tdata row = out_row of slot rd_ptr, each element sat(elem >>> SHIFT).
  - Saturation range: [-2^(W_RES-1), 2^(W_RES-1)-1]. Values inside the range are passed through sign-truncated.
  - out_tdata is driven from registered state only; no combinational path from valid_in/result_in.
  - out_tdata is 0 when count==0.
- Handshake:
  - A beat transfers when out_tvalid && out_tready.
  - While out_tvalid && !out_tready, out_tdata/out_tlast/out_row hold stable.
  - On transfer with out_row<N-1: out_row+1.
  - On transfer with out_row==N-1 (out_tlast=1): out_row<=0, toggle rd_ptr, count-1 (pop).
- Latency:
  - valid_in at edge t -> out_tvalid=1 after edge t when the buffer was empty.
  - Row 0 is presented immediately; with out_tready held high, a matrix drains in N cycles.
- Order: matrices leave in capture order; rows 0..N-1; no row is skipped or repeated.
- out_tready is ignored when out_tvalid=0.

Decomposition:
- Shared package mat_mul_pkg: N, W_IN, W_OUT defaults, W_RES, and a typedef for the packed result matrix (logic signed [N-1:0][N-1:0][W_OUT-1:0]) shared with mat_mul_wrapper.
- One sub-module: sat_shift_narrow (combinational, W_OUT->W_RES with SHIFT), instantiated N times for the row lanes.

Test Plan:
- Single result, all [i][j]=i*8+j, tready=1 -> 8 consecutive beats, row r lane j = r*8+j, tlast only on beat 8, busy low the cycle after.
- Saturation, SHIFT=0, W_RES=16: elements 40000, -40000, 32767, -32768, -1 -> 32767, -32768, 32767, -32768, -1. SHIFT=4: 0x123 -> 0x12, -1 -> -1, -33 -> -3.
- Backpressure: tready toggling 1,0,0,1 from row 2 -> data/out_row held while stalled, still 8 transfers in order, no duplicates.
- Burst: three valid_in pulses 1 cycle apart with tready=0 -> first two captured, third dropped, overflow=1. Releasing tready gives 16 beats (matrix A then B). clear_ovf -> overflow=0.
- Full with pop: count=2, valid_in coincident with the tlast transfer -> accepted, overflow stays 0, third matrix follows B.
- Reset mid-drain at row 3 -> outputs 0 immediately. A new result after release starts at row 0 with no stale rows.
